// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory port, execute redirect/halt inputs,
// decode-side valid/ready output and the sticky error flag.
interface fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic [15:0] pc_plus2;
   logic        err;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus2, err,
      input  imem_ready, imem_rdata, redirect, redirect_pc, halt, inst_ready
   );
   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus2, err,
      output imem_ready, imem_rdata, redirect, redirect_pc, halt, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ready, buffers them for decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the buffer is empty.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT   = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] HALTED = 2'd3;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] word;
   } entry_t;

   logic [1:0]       state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic [15:0]      addr_q, addr_d;
   logic             halt_pend_q, halt_pend_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   entry_t           mem_q [BUF_DEPTH];
   entry_t           mem_d [BUF_DEPTH];

   logic   flush, do_halt, do_redir, misalign, stop, outstanding, issue;
   logic   capture, bypass, push, pop, pop_buf;
   entry_t head;

   always_comb begin
      flush       = (bus.redirect | bus.halt) & (state_q != HALTED);
      do_halt     = bus.halt & (state_q != HALTED);
      do_redir    = bus.redirect & ~bus.halt & (state_q != HALTED);
      misalign    = do_redir & bus.redirect_pc[0];
      stop        = do_halt | misalign;
      outstanding = (state_q == WAIT) | (state_q == DRAIN);
      // rst_n gate keeps imem_req low while reset is held
      issue       = rst_n & (state_q == IDLE) & (count_q < DEPTH_C) & ~flush;

      bus.imem_req  = issue | outstanding;
      bus.imem_addr = outstanding ? addr_q : pc_q;

      // only a non-flushed return on the current path is kept
      capture = bus.imem_ready & ~flush & (issue | (state_q == WAIT));
`ifdef FETCH_BYPASS_EN
      bypass  = capture & (count_q == '0);
`else
      bypass  = 1'b0;
`endif
      head           = bypass ? entry_t'{pc: bus.imem_addr, word: bus.imem_rdata} : mem_q[rd_ptr_q];
      bus.inst_valid = ((count_q != '0) & ~flush) | bypass;
      bus.inst       = head.word;
      bus.inst_pc    = head.pc;
      bus.pc_plus2   = head.pc + 16'd2;
      bus.err        = err_q;

      pop     = bus.inst_valid & bus.inst_ready;
      pop_buf = pop & ~bypass;
      push    = capture & ~(bypass & bus.inst_ready);
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      halt_pend_d = halt_pend_q;
      err_d       = err_q | misalign;
      if (issue)   addr_d = pc_q;
      if (capture) pc_d   = pc_q + 16'd2;

      case (state_q)
         IDLE: begin
            if (stop)                            state_d = HALTED;
            else if (do_redir)                   pc_d    = bus.redirect_pc;
            else if (issue && !bus.imem_ready)   state_d = WAIT;
         end
         WAIT: begin
            if (stop) begin
               state_d     = bus.imem_ready ? HALTED : DRAIN;
               halt_pend_d = 1'b1;
            end else if (do_redir) begin
               pc_d    = bus.redirect_pc;
               state_d = bus.imem_ready ? IDLE : DRAIN;
            end else if (bus.imem_ready) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (stop)          halt_pend_d = 1'b1;
            else if (do_redir) pc_d        = bus.redirect_pc;
            if (bus.imem_ready) begin
               state_d     = (halt_pend_q | stop) ? HALTED : IDLE;
               halt_pend_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{pc: bus.imem_addr, word: bus.imem_rdata};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_buf) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop_buf})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         halt_pend_q <= 1'b0;
         err_q       <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         halt_pend_q <= halt_pend_d;
         err_q       <= err_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         mem_q       <= mem_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build, BUF_DEPTH=2, RESET_PC=0).
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   fetch_unit_if bus();
   fetch_unit #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // memory returns a word derived from its address so inst can be checked against inst_pc
   assign bus.imem_rdata = bus.imem_addr ^ 16'h1234;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.imem_ready  = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.halt        = 1'b0;
      bus.inst_ready  = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      idle_inputs();
      // reset state
      #2;
      check("rst_req",   bus.imem_req,   1'b0);
      check("rst_valid", bus.inst_valid, 1'b0);
      check("rst_err",   bus.err,        1'b0);
      check("rst_addr",  bus.imem_addr,  16'h0000);

      // back-to-back fetch, decode always ready
      do_reset();
      bus.imem_ready = 1'b1; bus.inst_ready = 1'b1;
      #2;
      check("bb_c0_req",   bus.imem_req,   1'b1);
      check("bb_c0_addr",  bus.imem_addr,  16'h0000);
      check("bb_c0_valid", bus.inst_valid, 1'b0);
      tick(); #2;
      check("bb_c1_addr",  bus.imem_addr,  16'h0002);
      check("bb_c1_valid", bus.inst_valid, 1'b1);
      check("bb_c1_pc",    bus.inst_pc,    16'h0000);
      check("bb_c1_p2",    bus.pc_plus2,   16'h0002);
      check("bb_c1_inst",  bus.inst,       16'h1234);
      tick(); #2;
      check("bb_c2_addr",  bus.imem_addr,  16'h0004);
      check("bb_c2_pc",    bus.inst_pc,    16'h0002);
      check("bb_c2_p2",    bus.pc_plus2,   16'h0004);
      tick(); #2;
      check("bb_c3_addr",  bus.imem_addr,  16'h0006);
      check("bb_c3_pc",    bus.inst_pc,    16'h0004);
      check("bb_c3_p2",    bus.pc_plus2,   16'h0006);

      // backpressure: buffer of 2 fills, then fetch stops
      do_reset();
      bus.imem_ready = 1'b1; bus.inst_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         if (bus.imem_req && bus.imem_ready) n++;
         tick();
      end
      check("bp_fetches", n, 2);
      #2;
      check("bp_req_off", bus.imem_req,   1'b0);
      check("bp_valid",   bus.inst_valid, 1'b1);
      check("bp_pc0",     bus.inst_pc,    16'h0000);
      bus.inst_ready = 1'b1;
      tick(); #2;
      check("bp_pc1",     bus.inst_pc,    16'h0002);
      check("bp_resume",  bus.imem_addr,  16'h0004);
      check("bp_req_on",  bus.imem_req,   1'b1);
      tick(); #2;
      check("bp_pc2",     bus.inst_pc,    16'h0004);
      check("bp_inst2",   bus.inst,       16'h1230);

      // redirect while a slow request is outstanding
      do_reset();
      bus.inst_ready = 1'b1;
      tick();
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
      #2;
      check("rd_c1_addr",  bus.imem_addr,  16'h0000);
      check("rd_c1_valid", bus.inst_valid, 1'b0);
      tick();
      bus.redirect = 1'b0;
      #2;
      check("rd_c2_req",   bus.imem_req,   1'b1);
      check("rd_c2_addr",  bus.imem_addr,  16'h0000);
      tick();
      bus.imem_ready = 1'b1;
      #2;
      check("rd_c3_addr",  bus.imem_addr,  16'h0000);
      check("rd_c3_valid", bus.inst_valid, 1'b0);
      tick(); #2;
      check("rd_c4_addr",  bus.imem_addr,  16'h0040);
      check("rd_c4_valid", bus.inst_valid, 1'b0);
      tick(); #2;
      check("rd_c5_valid", bus.inst_valid, 1'b1);
      check("rd_c5_pc",    bus.inst_pc,    16'h0040);
      check("rd_c5_inst",  bus.inst,       16'h1274);

      // PC wraps from FFFE to 0000
      do_reset();
      bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
      #2;
      check("wr_c0_req",  bus.imem_req, 1'b0);
      tick();
      bus.redirect = 1'b0; bus.imem_ready = 1'b1; bus.inst_ready = 1'b1;
      #2;
      check("wr_c1_addr", bus.imem_addr, 16'hFFFE);
      tick(); #2;
      check("wr_c2_addr", bus.imem_addr, 16'h0000);
      check("wr_c2_pc",   bus.inst_pc,   16'hFFFE);
      check("wr_c2_p2",   bus.pc_plus2,  16'h0000);
      check("wr_c2_err",  bus.err,       1'b0);

      // misaligned redirect halts with err; later redirect ignored; reset recovers
      do_reset();
      bus.imem_ready = 1'b1; bus.inst_ready = 1'b1;
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0013;
      tick();
      bus.redirect = 1'b0;
      #2;
      check("ma_err",  bus.err,      1'b1);
      check("ma_req",  bus.imem_req, 1'b0);
      tick();
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0020;
      tick();
      bus.redirect = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         #2;
         if (bus.imem_req || bus.inst_valid) n++;
         tick();
      end
      check("ma_quiet",    n,       0);
      check("ma_err_hold", bus.err, 1'b1);
      rst_n = 1'b0;
      #2;
      check("ma_rst_err", bus.err,       1'b0);
      check("ma_rst_req", bus.imem_req,  1'b0);
      tick();
      rst_n = 1'b1;
      #2;
      check("ma_restart_req",  bus.imem_req,  1'b1);
      check("ma_restart_addr", bus.imem_addr, 16'h0000);

      // halt and redirect together while a request is outstanding
      do_reset();
      tick();
      bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 16'h0080;
      #2;
      check("hl_c1_valid", bus.inst_valid, 1'b0);
      tick();
      bus.halt = 1'b0; bus.redirect = 1'b0;
      #2;
      check("hl_c2_req",   bus.imem_req,  1'b1);
      check("hl_c2_addr",  bus.imem_addr, 16'h0000);
      bus.imem_ready = 1'b1; bus.inst_ready = 1'b1;
      tick();
      n = 0;
      for (int i = 0; i < 5; i++) begin
         #2;
         if (bus.imem_req || bus.inst_valid) n++;
         tick();
      end
      check("hl_quiet", n,       0);
      check("hl_err",   bus.err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
